instruction_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS32 pipeline: owns the PC, issues word reads to instruction memory over a request/ready handshake, and drives the IF-side inputs of the IF/ID pipeline register (instruction, PC+4, usable PC, stall/flush/branch-delay qualifiers). It sits between the instruction memory port and the IF/ID register. It takes branch and exception redirects from ID and the hazard unit, and guarantees MIPS delay-slot semantics when memory has wait states.

---
 rtl/instruction_fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage of the 5-stage MIPS32 pipeline.
// Owns the PC and issues word reads over a read/ready handshake. It drives the IF side of the
// IF/ID register and keeps the branch delay slot intact across memory wait states.
// Optional feature macro: FETCH_SKID_BUFFER_EN. When it is defined, a one-entry buffer catches
// data that returns while ID is stalled, so that data is not fetched a second time.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_stall,
    input  logic        id_pc_src,
    input  logic [31:0] id_branch_target,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_add_4,
    output logic [31:0] if_pc_usable,
    output logic        if_stall,
    output logic        if_flush,
    output logic        if_bra_delay
);

    typedef enum logic [1:0] {StFetch = 2'd0, StDrain = 2'd1, StBuffer = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic        pending_valid_q, pending_valid_d;
    logic [31:0] drain_addr_q, drain_addr_d;
`ifdef FETCH_SKID_BUFFER_EN
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;
`else
    logic        outstanding_q, outstanding_d;
`endif

    logic [31:0] branch_pc;
    logic [31:0] redirect_pc;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic        mem_done;

    // Low address bits of redirect targets are ignored.
    assign branch_pc   = id_branch_target & 32'hFFFF_FFFC;
    assign redirect_pc = ex_target & 32'hFFFF_FFFC;

    // Next-state and output decode; everything is forced idle while reset is high.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        pending_target_d = pending_target_q;
        pending_valid_d  = pending_valid_q;
        drain_addr_d     = drain_addr_q;
`ifdef FETCH_SKID_BUFFER_EN
        buf_instr_d      = buf_instr_q;
        buf_pc_d         = buf_pc_q;
        buf_valid_d      = buf_valid_q;
`else
        outstanding_d    = 1'b0;
`endif
        deliver          = 1'b0;
        deliver_instr    = 32'h0;
        deliver_pc       = pc_q;
        mem_done         = 1'b0;
        imem_read        = 1'b0;
        imem_address     = pc_q;
        if_instruction   = 32'h0;
        if_pc_add_4      = 32'h0;
        if_pc_usable     = 32'h0;
        if_stall         = 1'b1;
        if_flush         = 1'b0;
        if_bra_delay     = 1'b0;

        if (!reset) begin
            if_flush = ex_redirect;
            // A taken branch whose delay slot is not delivered now is remembered;
            // delivery below overrides this.
            if (id_pc_src && !ex_redirect) begin
                pending_target_d = branch_pc;
                pending_valid_d  = 1'b1;
            end

            unique case (state_q)
                StFetch: begin
`ifdef FETCH_SKID_BUFFER_EN
                    imem_read = 1'b1;
`else
                    imem_read = !id_stall || outstanding_q;
`endif
                    mem_done = imem_read && imem_ready;
                    if (ex_redirect) begin
                        pc_d            = redirect_pc;
                        pending_valid_d = 1'b0;
                        // Request still in flight: wait it out without presenting it.
                        if (imem_read && !imem_ready) begin
                            state_d      = StDrain;
                            drain_addr_d = pc_q;
                        end
                    end else if (mem_done && !id_stall) begin
                        deliver       = 1'b1;
                        deliver_instr = imem_data;
`ifdef FETCH_SKID_BUFFER_EN
                    end else if (mem_done) begin
                        buf_instr_d = imem_data;
                        buf_pc_d    = pc_q;
                        buf_valid_d = 1'b1;
                        state_d     = StBuffer;
`endif
                    end
`ifndef FETCH_SKID_BUFFER_EN
                    // Data returning under stall is dropped; pc holds so it is re-read later.
                    outstanding_d = imem_read && !imem_ready && !ex_redirect;
`endif
                end
                StDrain: begin
                    // Keep showing the abandoned address until memory finishes with it.
                    imem_address = drain_addr_q;
                    if (ex_redirect) begin
                        pc_d            = redirect_pc;
                        pending_valid_d = 1'b0;
                    end
                    if (imem_ready) begin
                        state_d = StFetch;
                    end
                end
`ifdef FETCH_SKID_BUFFER_EN
                StBuffer: begin
                    if (ex_redirect) begin
                        pc_d            = redirect_pc;
                        pending_valid_d = 1'b0;
                        buf_valid_d     = 1'b0;
                        state_d         = StFetch;
                    end else if (!id_stall && buf_valid_q) begin
                        deliver       = 1'b1;
                        deliver_instr = buf_instr_q;
                        deliver_pc    = buf_pc_q;
                        buf_valid_d   = 1'b0;
                        state_d       = StFetch;
                    end
                end
`endif
                default: state_d = StFetch;
            endcase

            if (deliver) begin
                if_stall        = 1'b0;
                if_instruction  = deliver_instr;
                if_pc_usable    = deliver_pc;
                if_pc_add_4     = deliver_pc + 32'd4;
                pending_valid_d = 1'b0;
                if (pending_valid_q) begin
                    pc_d = pending_target_q;
                end else if (id_pc_src) begin
                    pc_d = branch_pc;
                end else begin
                    pc_d = deliver_pc + 32'd4;
                end
            end
            if_bra_delay = (pending_valid_q || id_pc_src) && !deliver;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= StFetch;
            pc_q             <= RESET_VECTOR;
            pending_target_q <= 32'h0;
            pending_valid_q  <= 1'b0;
            drain_addr_q     <= 32'h0;
`ifdef FETCH_SKID_BUFFER_EN
            buf_instr_q      <= 32'h0;
            buf_pc_q         <= 32'h0;
            buf_valid_q      <= 1'b0;
`else
            outstanding_q    <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            pending_target_q <= pending_target_d;
            pending_valid_q  <= pending_valid_d;
            drain_addr_q     <= drain_addr_d;
`ifdef FETCH_SKID_BUFFER_EN
            buf_instr_q      <= buf_instr_d;
            buf_pc_q         <= buf_pc_d;
            buf_valid_q      <= buf_valid_d;
`else
            outstanding_q    <= outstanding_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a wait-state instruction memory model.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset;
    logic        id_stall;
    logic        id_pc_src;
    logic [31:0] id_branch_target;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_add_4;
    logic [31:0] if_pc_usable;
    logic        if_stall;
    logic        if_flush;
    logic        if_bra_delay;

    int total;
    int bad;
    int waits;
    int cnt;
    logic busy;

    instruction_fetch_unit dut (
        .clock            (clock),
        .reset            (reset),
        .id_stall         (id_stall),
        .id_pc_src        (id_pc_src),
        .id_branch_target (id_branch_target),
        .ex_redirect      (ex_redirect),
        .ex_target        (ex_target),
        .imem_read        (imem_read),
        .imem_address     (imem_address),
        .imem_ready       (imem_ready),
        .imem_data        (imem_data),
        .if_instruction   (if_instruction),
        .if_pc_add_4      (if_pc_add_4),
        .if_pc_usable     (if_pc_usable),
        .if_stall         (if_stall),
        .if_flush         (if_flush),
        .if_bra_delay     (if_bra_delay)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        if (a == 32'hBFC0_0004) return 32'h2409_0002;
        return a ^ 32'h1234_5678;
    endfunction

    // Memory completes a request `waits` cycles after it is first seen, even if read drops.
    always @(posedge clock) begin
        if (reset) begin
            cnt  <= 0;
            busy <= 1'b0;
        end else if (imem_ready) begin
            cnt  <= 0;
            busy <= 1'b0;
        end else if (imem_read || busy) begin
            cnt  <= cnt + 1;
            busy <= 1'b1;
        end
    end
    assign imem_ready = !reset && (imem_read || busy) && (cnt >= waits);
    assign imem_data  = mem_word(imem_address);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        total = 0; bad = 0; waits = 0;
        reset = 1'b1; id_stall = 1'b0; id_pc_src = 1'b0; id_branch_target = 32'h0;
        ex_redirect = 1'b0; ex_target = 32'h0;

        // Reset outputs
        @(negedge clock); #1;
        @(negedge clock); #1;
        check_eq("rst_read", 32'(imem_read), 32'd0);
        check_eq("rst_stall", 32'(if_stall), 32'd1);
        check_eq("rst_instr", if_instruction, 32'h0);
        check_eq("rst_pc", if_pc_usable, 32'h0);
        check_eq("rst_pc4", if_pc_add_4, 32'h0);
        check_eq("rst_flush", 32'(if_flush), 32'd0);
        check_eq("rst_bd", 32'(if_bra_delay), 32'd0);

        // Zero-wait back-to-back fetch
        @(negedge clock); reset = 1'b0; #1;
        check_eq("zw0_read", 32'(imem_read), 32'd1);
        check_eq("zw0_stall", 32'(if_stall), 32'd0);
        check_eq("zw0_pc", if_pc_usable, 32'hBFC0_0000);
        check_eq("zw0_instr", if_instruction, 32'h2408_0001);
        @(negedge clock); #1;
        check_eq("zw1_stall", 32'(if_stall), 32'd0);
        check_eq("zw1_pc", if_pc_usable, 32'hBFC0_0004);
        check_eq("zw1_instr", if_instruction, 32'h2409_0002);
        check_eq("zw1_pc4", if_pc_add_4, 32'hBFC0_0008);

        // Three wait states
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); waits = 3; #1;
            check_eq("ws_stall", 32'(if_stall), 32'd1);
            check_eq("ws_addr", imem_address, 32'hBFC0_0008);
        end
        @(negedge clock); #1;
        check_eq("ws_done_stall", 32'(if_stall), 32'd0);
        check_eq("ws_done_pc", if_pc_usable, 32'hBFC0_0008);
        check_eq("ws_done_instr", if_instruction, 32'hADF4_5670);

        // Branch with delay slot under two wait states
        @(negedge clock); waits = 2; id_pc_src = 1'b1; id_branch_target = 32'h8000_0100; #1;
        check_eq("br_a_bd", 32'(if_bra_delay), 32'd1);
        check_eq("br_a_stall", 32'(if_stall), 32'd1);
        @(negedge clock); id_pc_src = 1'b0; id_branch_target = 32'h0; #1;
        check_eq("br_b_bd", 32'(if_bra_delay), 32'd1);
        check_eq("br_b_addr", imem_address, 32'hBFC0_000C);
        @(negedge clock); #1;
        check_eq("br_c_bd", 32'(if_bra_delay), 32'd0);
        check_eq("br_c_pc", if_pc_usable, 32'hBFC0_000C);
        check_eq("br_c_instr", if_instruction, 32'hADF4_5674);
        @(negedge clock); waits = 0; #1;
        check_eq("br_d_addr", imem_address, 32'h8000_0100);
        check_eq("br_d_pc", if_pc_usable, 32'h8000_0100);
        check_eq("br_d_instr", if_instruction, 32'h9234_5778);
        check_eq("br_d_pc4", if_pc_add_4, 32'h8000_0104);

        // Exception redirect while a request is outstanding
        @(negedge clock); waits = 3; ex_redirect = 1'b1; ex_target = 32'h8000_0180; #1;
        check_eq("ex_e_flush", 32'(if_flush), 32'd1);
        check_eq("ex_e_stall", 32'(if_stall), 32'd1);
        @(negedge clock); ex_redirect = 1'b0; ex_target = 32'h0; #1;
        check_eq("ex_f_read", 32'(imem_read), 32'd0);
        check_eq("ex_f_addr", imem_address, 32'h8000_0104);
        check_eq("ex_f_stall", 32'(if_stall), 32'd1);
        check_eq("ex_f_flush", 32'(if_flush), 32'd0);
        @(negedge clock); #1;
        check_eq("ex_g_stall", 32'(if_stall), 32'd1);
        @(negedge clock); #1;
        check_eq("ex_h_ready", 32'(imem_ready), 32'd1);
        check_eq("ex_h_stall", 32'(if_stall), 32'd1);
        check_eq("ex_h_read", 32'(imem_read), 32'd0);
        @(negedge clock); waits = 0; #1;
        check_eq("ex_i_addr", imem_address, 32'h8000_0180);
        check_eq("ex_i_stall", 32'(if_stall), 32'd0);
        check_eq("ex_i_instr", if_instruction, 32'h9234_57F8);

        // ID stall for four cycles while the read completes
        @(negedge clock); waits = 1; #1;
        check_eq("st_j_stall", 32'(if_stall), 32'd1);
        check_eq("st_j_addr", imem_address, 32'h8000_0184);
        @(negedge clock); id_stall = 1'b1; #1;
        check_eq("st_k_ready", 32'(imem_ready), 32'd1);
        check_eq("st_k_stall", 32'(if_stall), 32'd1);
        check_eq("st_k_addr", imem_address, 32'h8000_0184);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check_eq("st_hold_read", 32'(imem_read), 32'd0);
            check_eq("st_hold_stall", 32'(if_stall), 32'd1);
        end
        @(negedge clock); id_stall = 1'b0; #1;
`ifdef FETCH_SKID_BUFFER_EN
        check_eq("sb_o_read", 32'(imem_read), 32'd0);
        check_eq("sb_o_stall", 32'(if_stall), 32'd0);
        check_eq("sb_o_pc", if_pc_usable, 32'h8000_0184);
        check_eq("sb_o_instr", if_instruction, 32'h9234_57FC);
        @(negedge clock); #1;
        check_eq("sb_p_addr", imem_address, 32'h8000_0188);
`else
        check_eq("st_o_read", 32'(imem_read), 32'd1);
        check_eq("st_o_addr", imem_address, 32'h8000_0184);
        check_eq("st_o_stall", 32'(if_stall), 32'd1);
        @(negedge clock); #1;
        check_eq("st_p_stall", 32'(if_stall), 32'd0);
        check_eq("st_p_pc", if_pc_usable, 32'h8000_0184);
        check_eq("st_p_instr", if_instruction, 32'h9234_57FC);
        @(negedge clock); #1;
        check_eq("st_q_addr", imem_address, 32'h8000_0188);
`endif

        // Redirect with data ready, then wrap past the top of the address space
        waits = 0; ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFF; #1;
        check_eq("wr_q_flush", 32'(if_flush), 32'd1);
        check_eq("wr_q_stall", 32'(if_stall), 32'd1);
        @(negedge clock); ex_redirect = 1'b0; ex_target = 32'h0; #1;
        check_eq("wr_r_addr", imem_address, 32'hFFFF_FFFC);
        check_eq("wr_r_pc", if_pc_usable, 32'hFFFF_FFFC);
        check_eq("wr_r_pc4", if_pc_add_4, 32'h0000_0000);
        check_eq("wr_r_instr", if_instruction, 32'hEDCB_A984);
        @(negedge clock); #1;
        check_eq("wr_s_addr", imem_address, 32'h0000_0000);
        check_eq("wr_s_pc", if_pc_usable, 32'h0000_0000);

        // Branch and exception together: exception wins
        @(negedge clock); id_pc_src = 1'b1; id_branch_target = 32'h1234_5678;
        ex_redirect = 1'b1; ex_target = 32'h0000_0400; #1;
        check_eq("bx_t_flush", 32'(if_flush), 32'd1);
        check_eq("bx_t_stall", 32'(if_stall), 32'd1);
        @(negedge clock); id_pc_src = 1'b0; id_branch_target = 32'h0;
        ex_redirect = 1'b0; ex_target = 32'h0; #1;
        check_eq("bx_u_addr", imem_address, 32'h0000_0400);
        check_eq("bx_u_bd", 32'(if_bra_delay), 32'd0);
        @(negedge clock); #1;
        check_eq("bx_v_addr", imem_address, 32'h0000_0404);

        // Reset while a request is outstanding
        @(negedge clock); waits = 3; #1;
        check_eq("rm_w0_stall", 32'(if_stall), 32'd1);
        check_eq("rm_w0_addr", imem_address, 32'h0000_0408);
        @(negedge clock); reset = 1'b1; #1;
        check_eq("rm_w_read", 32'(imem_read), 32'd0);
        check_eq("rm_w_stall", 32'(if_stall), 32'd1);
        @(negedge clock); reset = 1'b0; waits = 0; #1;
        check_eq("rm_x_addr", imem_address, 32'hBFC0_0000);
        check_eq("rm_x_pc", if_pc_usable, 32'hBFC0_0000);
        check_eq("rm_x_instr", if_instruction, 32'h2408_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
